// File: rtl/draw_grid_bg.sv
// rtl/draw_grid_bg.sv - grid background renderer with one highlightable cell, 2-cycle pipelined
module draw_grid_bg #(
    parameter int          H_ACTIVE = 1024,
    parameter int          V_ACTIVE = 768,
    parameter int          CELLS    = 3,
    parameter int          CELL_W   = 200,
    parameter int          CELL_H   = 200,
    parameter int          ORG_X    = 212,
    parameter int          ORG_Y    = 84,
    parameter int          LINE_W   = 8,
    parameter int          EDGE_EN  = 1,
    parameter logic [11:0] BG_RGB   = 12'h888,
    parameter logic [11:0] LINE_RGB = 12'hfff,
    parameter logic [11:0] HL_RGB   = 12'h08f
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [2:0]  sel_col,
    input  logic [2:0]  sel_row,
    input  logic        sel_valid,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] X_BEG   = 11'(ORG_X);
    localparam logic [10:0] Y_BEG   = 11'(ORG_Y);
    localparam logic [11:0] X_END   = 12'(ORG_X + CELLS * CELL_W);
    localparam logic [11:0] Y_END   = 12'(ORG_Y + CELLS * CELL_H);
    localparam logic [7:0]  XO_LAST = 8'(CELL_W - 1);
    localparam logic [7:0]  YO_LAST = 8'(CELL_H - 1);
    localparam logic [7:0]  LW      = 8'(LINE_W);
    localparam logic [2:0]  CMAX    = 3'(CELLS - 1);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST  = 11'(V_ACTIVE - 1);

    logic [7:0]  xo_q, xo_d, xo_cur, yo_q, yo_d, yo_cur;
    logic [2:0]  col_q, col_d, col_cur, row_q, row_d, row_cur;
    logic        vblnk_prev_q;
    logic [2:0]  sel_col_q, sel_row_q;
    logic        sel_valid_q;
    logic        in_grid, grid_line, hl;
    logic [11:0] rgb_d;

    logic [10:0] s1_hcount_q, s1_vcount_q;
    logic        s1_hsync_q, s1_hblnk_q, s1_vsync_q, s1_vblnk_q;
    logic [11:0] s1_rgb_q;

    always_comb begin
        xo_cur  = xo_q;
        col_cur = col_q;
        if (hcount_in == X_BEG) begin
            xo_cur  = '0;
            col_cur = '0;
        end
        xo_d  = (xo_cur == XO_LAST) ? 8'd0 : xo_cur + 8'd1;
        col_d = col_cur;
        if (xo_cur == XO_LAST && col_cur != CMAX)
            col_d = col_cur + 3'd1;

        // Rows advance once per line, on the hcount_in==0 cycle.
        yo_cur  = yo_q;
        row_cur = row_q;
        if (hcount_in == 11'd0) begin
            if (vcount_in == Y_BEG) begin
                yo_cur  = '0;
                row_cur = '0;
            end else begin
                yo_cur = (yo_q == YO_LAST) ? 8'd0 : yo_q + 8'd1;
                if (yo_q == YO_LAST && row_q != CMAX)
                    row_cur = row_q + 3'd1;
            end
        end
        yo_d  = yo_cur;
        row_d = row_cur;

        in_grid   = (hcount_in >= X_BEG) && ({1'b0, hcount_in} < X_END) &&
                    (vcount_in >= Y_BEG) && ({1'b0, vcount_in} < Y_END);
        grid_line = in_grid && ((col_cur != 3'd0 && xo_cur < LW) ||
                                (row_cur != 3'd0 && yo_cur < LW));
        hl        = in_grid && sel_valid_q && col_cur == sel_col_q && row_cur == sel_row_q;

        rgb_d = BG_RGB;
        if (hblnk_in || vblnk_in)                       rgb_d = 12'h000;
        else if (EDGE_EN != 0 && vcount_in == 11'd0)    rgb_d = 12'hff0;
        else if (EDGE_EN != 0 && vcount_in == V_LAST)   rgb_d = 12'hf00;
        else if (EDGE_EN != 0 && hcount_in == 11'd0)    rgb_d = 12'h0f0;
        else if (EDGE_EN != 0 && hcount_in == H_LAST)   rgb_d = 12'h00f;
        else if (grid_line)                             rgb_d = LINE_RGB;
        else if (hl)                                    rgb_d = HL_RGB;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            xo_q         <= '0;
            yo_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            vblnk_prev_q <= 1'b0;
            sel_col_q    <= '0;
            sel_row_q    <= '0;
            sel_valid_q  <= 1'b0;
        end else begin
            xo_q         <= xo_d;
            yo_q         <= yo_d;
            col_q        <= col_d;
            row_q        <= row_d;
            vblnk_prev_q <= vblnk_in;
            if (vblnk_in && !vblnk_prev_q) begin
                sel_col_q   <= sel_col;
                sel_row_q   <= sel_row;
                sel_valid_q <= sel_valid;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s1_hcount_q <= '0;
            s1_vcount_q <= '0;
            s1_hsync_q  <= 1'b0;
            s1_hblnk_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_vblnk_q  <= 1'b0;
            s1_rgb_q    <= '0;
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vsync_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            rgb_out     <= '0;
        end else begin
            s1_hcount_q <= hcount_in;
            s1_vcount_q <= vcount_in;
            s1_hsync_q  <= hsync_in;
            s1_hblnk_q  <= hblnk_in;
            s1_vsync_q  <= vsync_in;
            s1_vblnk_q  <= vblnk_in;
            s1_rgb_q    <= rgb_d;
            hcount_out  <= s1_hcount_q;
            vcount_out  <= s1_vcount_q;
            hsync_out   <= s1_hsync_q;
            hblnk_out   <= s1_hblnk_q;
            vsync_out   <= s1_vsync_q;
            vblnk_out   <= s1_vblnk_q;
            rgb_out     <= s1_rgb_q;
        end
    end

endmodule
